// File: rtl/elevator_request_scheduler_if.sv
// Bundle between the elevator request scheduler and its neighbours: raw
// buttons and controller status in, latched requests and target out.
// All signals are plain levels sampled on the rising clock edge; there is
// no valid/ready handshake. target_valid qualifies target_floor on every
// cycle and the consumer may sample both at any edge.
interface elevator_request_scheduler_if #(
    parameter int NUM_FLOORS = 16,
    parameter int FLOOR_W    = 4
);
    logic [NUM_FLOORS-1:0] floor_buttons;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  door_open;
    logic [NUM_FLOORS-1:0] pending;
    logic [FLOOR_W-1:0]    target_floor;
    logic                  target_valid;
    logic                  dir_up;
    logic                  dir_down;
    logic [FLOOR_W:0]      request_count;

    // Button panel / elevator controller side
    modport master (
        output floor_buttons, current_floor, door_open,
        input  pending, target_floor, target_valid, dir_up, dir_down, request_count
    );

    // Scheduler side
    modport slave (
        input  floor_buttons, current_floor, door_open,
        output pending, target_floor, target_valid, dir_up, dir_down, request_count
    );
endinterface

// File: rtl/elevator_request_scheduler.sv
// SCAN (collective) elevator request scheduler. Latches button presses as
// pending requests, clears them when the door opens at that floor, and
// steers the controller toward the next floor in the current sweep.
module elevator_request_scheduler #(
    parameter int NUM_FLOORS = 16,
    parameter int FLOOR_W    = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    elevator_request_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_FLOORS-1:0] btn_q, btn_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [FLOOR_W:0]      request_count_q, request_count_d;
    logic [FLOOR_W-1:0]    target_floor_q, target_floor_d;
    logic                  target_valid_q, target_valid_d;
    logic                  dir_up_q, dir_up_d;
    logic                  dir_down_q, dir_down_d;

    logic [NUM_FLOORS-1:0] set_vec;
    logic [NUM_FLOORS-1:0] clr_vec;
    logic                  cf_valid;
    logic                  above, below, here;
    logic [FLOOR_W-1:0]    lowest_above, highest_below;
    logic [FLOOR_W-1:0]    dist_up, dist_down;
    logic                  prefer_up;

    // Rising-edge capture of buttons and pending-request bookkeeping; a clear
    // at the open-door floor overrides a simultaneous press there.
    always_comb begin
        btn_d    = bus.floor_buttons;
        set_vec  = bus.floor_buttons & ~btn_q;
        clr_vec  = '0;
        cf_valid = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (bus.current_floor == FLOOR_W'(i)) begin
                cf_valid   = 1'b1;
                clr_vec[i] = bus.door_open;
            end
        end
        pending_d       = (pending_q | set_vec) & ~clr_vec;
        request_count_d = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            request_count_d = request_count_d + {{FLOOR_W{1'b0}}, pending_d[i]};
        end
    end

    // Summarise registered requests relative to the car: nearest above,
    // nearest below, and whether the current floor itself is requested.
    // An out-of-range floor is "no floor": everything pending counts as below.
    always_comb begin
        above         = 1'b0;
        below         = 1'b0;
        here          = 1'b0;
        lowest_above  = '0;
        highest_below = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_q[i]) begin
                if (!cf_valid || (FLOOR_W'(i) < bus.current_floor)) begin
                    below         = 1'b1;
                    highest_below = FLOOR_W'(i);
                end else if (FLOOR_W'(i) > bus.current_floor) begin
                    if (!above) begin
                        lowest_above = FLOOR_W'(i);
                    end
                    above = 1'b1;
                end else begin
                    here = 1'b1;
                end
            end
        end
        dist_up   = lowest_above - bus.current_floor;
        dist_down = bus.current_floor - highest_below;
        prefer_up = (dist_up <= dist_down);
    end

    // Next-state: keep sweeping while requests remain ahead, reverse when
    // only requests behind remain, and from IDLE head to the nearer side.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (above && below) begin
                    state_d = prefer_up ? ST_UP : ST_DOWN;
                end else if (above) begin
                    state_d = ST_UP;
                end else if (below) begin
                    state_d = ST_DOWN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_UP: begin
                if (!above) begin
                    state_d = below ? ST_DOWN : ST_IDLE;
                end
            end
            ST_DOWN: begin
                if (!below) begin
                    state_d = above ? ST_UP : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs for the state being entered; target holds when not valid.
    always_comb begin
        target_floor_d = target_floor_q;
        target_valid_d = 1'b0;
        dir_up_d       = (state_d == ST_UP);
        dir_down_d     = (state_d == ST_DOWN);
        case (state_d)
            ST_UP: begin
                target_floor_d = lowest_above;
                target_valid_d = 1'b1;
            end
            ST_DOWN: begin
                target_floor_d = highest_below;
                target_valid_d = 1'b1;
            end
            default: begin
                if (here) begin
                    target_floor_d = bus.current_floor;
                    target_valid_d = 1'b1;
                end
            end
        endcase
    end

    // State and output registers; buttons held through reset are absorbed.
    always_ff @(posedge clk) begin
        btn_q <= btn_d;
        if (reset) begin
            state_q         <= ST_IDLE;
            pending_q       <= '0;
            request_count_q <= '0;
            target_floor_q  <= '0;
            target_valid_q  <= 1'b0;
            dir_up_q        <= 1'b0;
            dir_down_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            pending_q       <= pending_d;
            request_count_q <= request_count_d;
            target_floor_q  <= target_floor_d;
            target_valid_q  <= target_valid_d;
            dir_up_q        <= dir_up_d;
            dir_down_q      <= dir_down_d;
        end
    end

    assign bus.pending       = pending_q;
    assign bus.request_count = request_count_q;
    assign bus.target_floor  = target_floor_q;
    assign bus.target_valid  = target_valid_q;
    assign bus.dir_up        = dir_up_q;
    assign bus.dir_down      = dir_down_q;

endmodule
